// File: rtl/regfile_read_port.sv
// 8-entry register bank with one write port and a handshaked, registered dual-operand read port.
// Entry 0 is hardwired to zero. Same-cycle writes bypass into captured operands.
module regfile_read_port #(
    parameter int W  = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W:0]    wr_data,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W:0]    rd_data_a,
    output logic [W:0]    rd_data_b
);

    localparam int DEPTH = 2 ** AW;

    logic [W:0] mem [DEPTH];
    logic       wr_act;
    logic       accept;
    logic [W:0] next_a;
    logic [W:0] next_b;

    assign wr_act    = wr_en && (wr_addr != '0);
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    // Address 0 reads as zero even if a bypass would match it.
    always_comb begin
        next_a = '0;
        next_b = '0;
        if (rd_addr_a != '0) begin
            if (wr_act && (wr_addr == rd_addr_a)) begin
                next_a = wr_data;
            end else begin
                next_a = mem[rd_addr_a];
            end
        end
        if (rd_addr_b != '0) begin
            if (wr_act && (wr_addr == rd_addr_b)) begin
                next_b = wr_data;
            end else begin
                next_b = mem[rd_addr_b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (wr_act) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rd_data_a <= next_a;
            rd_data_b <= next_b;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Read-side companion to the team's clocked data register: an 8-entry register bank with one write port and a handshaked dual-operand read port.
- Supplies operand pairs A and B to the ALU datapath.
- Reads are registered, so each operand pair is a snapshot taken when the request is accepted.
- Includes write-to-read bypass and a stall-tolerant output stage.

Parameters:
- W, 32, MSB index of the data word. The data width is W+1 bits (default 33), matching the team register convention [W:0].
- AW, 3, address width. The bank has 2**AW entries.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write strobe
- wr_addr  input  AW  write address
- wr_data  input  W+1  write data
- req_valid  input  1  read request valid
- req_ready  output  1  read request can be accepted
- rd_addr_a  input  AW  operand A address
- rd_addr_b  input  AW  operand B address
- rsp_valid  output  1  operand pair valid
- rsp_ready  input  1  consumer accepts the operand pair
- rd_data_a  output  W+1  operand A
- rd_data_b  output  W+1  operand B

Behaviour:
- Reset, sampled on the rising clk edge while rst=1:
  - All bank entries clear to 0.
  - rsp_valid=0, rd_data_a=0, rd_data_b=0.
  - Reset overrides any concurrent write or request, including mid-stall; an in-flight response is discarded.
- Entry 0 is hardwired to zero:
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0, including under bypass.
- Write:
  - When wr_en=1 and wr_addr!=0, the bank entry is updated at the clock edge.
  - Writes are independent of the read handshake and never stall.
- Request handshake:
  - req_ready = !rsp_valid || rsp_ready. This is combinational from rsp_valid and rsp_ready only, not from req_valid.
  - A request is accepted on an edge where req_valid && req_ready.
- Latency: exactly 1 cycle. An operand pair accepted at edge N is presented with rsp_valid=1 after edge N.
- Bypass: if the write is active (wr_en=1, wr_addr!=0) in the same cycle a request is accepted, and wr_addr equals rd_addr_a or rd_addr_b, the matching operand captures wr_data instead of the old bank value. Both operands may bypass.
- Snapshot semantics: while rsp_valid=1 and rsp_ready=0, rd_data_a, rd_data_b and rsp_valid hold stable. Later writes to the same addresses do not alter the held operands.
- Response completion:
  - When rsp_valid && rsp_ready and no new request is accepted, rsp_valid falls to 0 on the next edge.
  - rd_data_a and rd_data_b keep their last values.
- Back-to-back:
  - Accept and complete in the same cycle gives full throughput of one pair per cycle.
  - rsp_valid stays 1 and the data updates to the new pair.
- req_valid=0: no capture. Ignore the rd_addr_* inputs.
- Same address on A and B is legal; both outputs carry an identical value.
- Addresses wrap naturally within AW bits. There are no out-of-range addresses.
- No combinational path from wr_* or rd_addr_* to the rd_data_* outputs.

Test Plan:
- Reset, then request A=3, B=5 with rsp_ready=1 -> the cycle after acceptance shows rsp_valid=1, rd_data_a=0, rd_data_b=0.
- Write r3=0x1_2345_6789, wait 1 cycle, request A=3, B=0 -> rd_data_a=0x1_2345_6789, rd_data_b=0. Then write r0=0x5 and read A=0 -> 0.
- Bypass: write r4=0x0_0000_00AA in the same cycle as request A=4, B=4 -> both operands are 0xAA (not the old value 0).
- Stall: rsp_ready=0 holding pair (r2=7, r6=9); write r2=0x11; hold 3 cycles -> outputs stay 7/9, req_ready=0, a new req_valid is not accepted. Raise rsp_ready -> req_ready=1 the same cycle.
- Streaming: 8 consecutive requests A=i, B=7-i with rsp_ready=1 after bank fill r_i=i*0x10 -> 8 consecutive valid cycles with correct pairs and no bubbles.
- Reset mid-stall with rsp_valid=1 and a simultaneous wr_en to r5 -> next cycle rsp_valid=0, outputs 0; a subsequent read of r5 returns 0.
